// File: rtl/mpp_pkg.sv
// Shared types and constants for the MPP microprogram sequencer.
// Control-store bank A packs seq op, branch target and the top control bits.
package mpp_pkg;

    localparam int CTRL_W = 28;
    localparam int UPC_W  = 8;
    localparam int CS_W   = 20;

    localparam int CS_OP_LSB   = 16;
    localparam int CS_TGT_LSB  = 8;
    localparam int CS_CTRL_LSB = 0;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } seq_state_t;

    typedef logic [3:0] seq_op_t;

    localparam seq_op_t OP_NEXT  = 4'd0;
    localparam seq_op_t OP_JUMP  = 4'd1;
    localparam seq_op_t OP_BRZ   = 4'd2;
    localparam seq_op_t OP_BRC   = 4'd3;
    localparam seq_op_t OP_CALL  = 4'd4;
    localparam seq_op_t OP_RET   = 4'd5;
    localparam seq_op_t OP_WAIT  = 4'd6;
    localparam seq_op_t OP_FETCH = 4'd7;
    localparam seq_op_t OP_HALT  = 4'd15;

endpackage

// File: rtl/micro_sequencer_if.sv
// Bus bundle between the micro-sequencer and its instruction source, RAMs and datapath.
interface micro_sequencer_if;
    import mpp_pkg::*;

    logic [7:0]        instruction;
    logic              instr_valid;
    logic              instr_req;
    logic              dec_en;
    logic [3:0]        dec_addr;
    logic [7:0]        dec_data;
    logic              cs_en;
    logic [UPC_W-1:0]  cs_addr;
    logic [CS_W-1:0]   cs_a_data;
    logic [CS_W-1:0]   cs_b_data;
    logic              flag_z;
    logic              flag_c;
    logic              ext_ready;
    logic [CTRL_W-1:0] ctrl_signals;
    logic              ctrl_valid;
    logic [UPC_W-1:0]  upc;
    logic              halted;
    logic              err;

    modport master (
        input  instruction, instr_valid, dec_data, cs_a_data, cs_b_data,
               flag_z, flag_c, ext_ready,
        output instr_req, dec_en, dec_addr, cs_en, cs_addr,
               ctrl_signals, ctrl_valid, upc, halted, err
    );

    modport slave (
        output instruction, instr_valid, dec_data, cs_a_data, cs_b_data,
               flag_z, flag_c, ext_ready,
        input  instr_req, dec_en, dec_addr, cs_en, cs_addr,
               ctrl_signals, ctrl_valid, upc, halted, err
    );

endinterface

// File: rtl/useq_stack.sv
// Micro-return LIFO; top always shows the most recent entry so RET can jump the same cycle.
module useq_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      count;
    logic [PW-1:0]    top_idx;

    assign top_idx = count[PW-1:0] - PW'(1);
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign top     = mem[top_idx];

    // DEPTH is a power of two, so the low pointer bits wrap exactly onto the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (push && !full) begin
            mem[count[PW-1:0]] <= din;
            count              <= count + (PW+1)'(1);
        end else if (pop && !empty) begin
            count <= count - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: fetch, decode-RAM lookup, then step the micro-PC through the control store.
// state    | meaning
// S_RESET  | one quiet cycle after reset
// S_FETCH  | waiting for an instruction, decode RAM read on accept
// S_DECODE | entry address arrives, first control-store read issued
// S_EXEC   | one control word per cycle, next address from seq op
// S_HALT   | stopped until reset
module micro_sequencer
    import mpp_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    micro_sequencer_if.master bus
);

    seq_state_t       state;
    logic [UPC_W-1:0] upc_q;
    logic             err_q;

    seq_op_t          op;
    logic [UPC_W-1:0] target;
    logic [UPC_W-1:0] upc_inc;
    logic [UPC_W-1:0] next_upc;
    logic [UPC_W-1:0] stack_top;
    logic             stay_exec;
    logic             fault;
    logic             word_ready;
    logic             push;
    logic             pop;
    logic             stack_full;
    logic             stack_empty;
    logic             in_exec;
    logic             run;

    assign run     = !rst;
    assign in_exec = (state == S_EXEC);
    assign op      = bus.cs_a_data[CS_OP_LSB +: 4];
    assign target  = bus.cs_a_data[CS_TGT_LSB +: UPC_W];
    assign upc_inc = upc_q + UPC_W'(1);

    always_comb begin
        next_upc   = upc_inc;
        stay_exec  = 1'b1;
        fault      = 1'b0;
        word_ready = 1'b1;
        push       = 1'b0;
        pop        = 1'b0;
        case (op)
            OP_NEXT: ;
            OP_JUMP: next_upc = target;
            OP_BRZ:  if (bus.flag_z) next_upc = target;
            OP_BRC:  if (bus.flag_c) next_upc = target;
            OP_CALL: begin
                if (stack_full) begin
                    fault = 1'b1;
                end else begin
                    push     = 1'b1;
                    next_upc = target;
                end
            end
            OP_RET: begin
                if (stack_empty) begin
                    fault = 1'b1;
                end else begin
                    pop      = 1'b1;
                    next_upc = stack_top;
                end
            end
            OP_WAIT: begin
                if (!bus.ext_ready) begin
                    next_upc   = upc_q;
                    word_ready = 1'b0;
                end
            end
            OP_FETCH, OP_HALT: stay_exec = 1'b0;
            default: fault = 1'b1;
        endcase
        if (fault) stay_exec = 1'b0;
    end

    useq_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (UPC_W)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (in_exec && push),
        .pop   (in_exec && pop),
        .din   (upc_inc),
        .top   (stack_top),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RESET;
            upc_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_RESET: state <= S_FETCH;
                S_FETCH: if (bus.instr_valid) state <= S_DECODE;
                S_DECODE: begin
                    upc_q <= bus.dec_data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (fault) begin
                        err_q <= 1'b1;
                        state <= S_HALT;
                    end else if (stay_exec) begin
                        upc_q <= next_upc;
                    end else if (op == OP_HALT) begin
                        state <= S_HALT;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_RESET;
            endcase
        end
    end

    // Every output is forced low while rst is high so an aborted word never commits.
    assign bus.instr_req    = run && (state == S_FETCH);
    assign bus.dec_en       = run && (state == S_FETCH) && bus.instr_valid;
    assign bus.dec_addr     = bus.dec_en ? bus.instruction[7:4] : 4'd0;
    assign bus.cs_en        = run && ((state == S_DECODE) || in_exec);
    assign bus.cs_addr      = !run                ? '0 :
                              (state == S_DECODE) ? bus.dec_data :
                              in_exec             ? next_upc : '0;
    assign bus.ctrl_signals = (run && in_exec) ?
                              {bus.cs_a_data[CS_CTRL_LSB +: CTRL_W-CS_W], bus.cs_b_data} : '0;
    assign bus.ctrl_valid   = run && in_exec && word_ready;
    assign bus.upc          = run ? upc_q : '0;
    assign bus.halted       = run && (state == S_HALT);
    assign bus.err          = run && err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: RAM responders, a behavioural model and per-cycle output compare.
module tb_micro_sequencer;
    import mpp_pkg::*;

    localparam int DEPTH    = 4;
    localparam int P_BOOT   = 0;
    localparam int P_IDLE   = 1;
    localparam int P_LOOKUP = 2;
    localparam int P_RUN    = 3;
    localparam int P_STOP   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    micro_sequencer_if bus();

    micro_sequencer #(.STACK_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  dec_mem  [16];
    logic [19:0] cs_a_mem [256];
    logic [19:0] cs_b_mem [256];

    always @(posedge clk) begin
        if (bus.dec_en) bus.dec_data <= dec_mem[bus.dec_addr];
        if (bus.cs_en) begin
            bus.cs_a_data <= cs_a_mem[bus.cs_addr];
            bus.cs_b_data <= cs_b_mem[bus.cs_addr];
        end
    end

    int         m_ph;
    logic [7:0] m_upc;
    logic [7:0] m_entry;
    logic       m_err;
    logic [7:0] m_stack [$];
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sequencing rule for the word at the model's micro-PC; go: 0 stay, 1 fetch, 2 stop.
    task automatic decide(output logic [7:0] nxt, output int go, output logic fault, output logic ok);
        logic [3:0] op;
        logic [7:0] tgt;
        op    = cs_a_mem[m_upc][19:16];
        tgt   = cs_a_mem[m_upc][15:8];
        nxt   = m_upc + 8'd1;
        go    = 0;
        fault = 1'b0;
        ok    = 1'b1;
        case (op)
            4'd0: ;
            4'd1: nxt = tgt;
            4'd2: if (bus.flag_z) nxt = tgt;
            4'd3: if (bus.flag_c) nxt = tgt;
            4'd4: if (m_stack.size() >= DEPTH) fault = 1'b1; else nxt = tgt;
            4'd5: if (m_stack.size() == 0) fault = 1'b1; else nxt = m_stack[$];
            4'd6: if (!bus.ext_ready) begin nxt = m_upc; ok = 1'b0; end
            4'd7: go = 1;
            4'd15: go = 2;
            default: fault = 1'b1;
        endcase
        if (fault) go = 2;
    endtask

    task automatic check_outputs();
        logic [7:0]  nxt;
        int          go;
        logic        fault, ok;
        logic [31:0] e_req, e_den, e_dad, e_cen, e_cad, e_ctl, e_val, e_upc, e_hlt, e_err;
        logic        addr_known;
        decide(nxt, go, fault, ok);
        addr_known = 1'b1;
        if (rst) begin
            {e_req, e_den, e_dad, e_cen, e_cad} = '0;
            {e_ctl, e_val, e_upc, e_hlt, e_err} = '0;
        end else begin
            e_req = 32'(m_ph == P_IDLE);
            e_den = 32'((m_ph == P_IDLE) && bus.instr_valid);
            e_dad = e_den[0] ? 32'(bus.instruction[7:4]) : 32'd0;
            e_cen = 32'((m_ph == P_LOOKUP) || (m_ph == P_RUN));
            e_cad = (m_ph == P_LOOKUP) ? 32'(m_entry) : (m_ph == P_RUN) ? 32'(nxt) : 32'd0;
            if (m_ph == P_RUN && go != 0) addr_known = 1'b0;
            e_ctl = (m_ph == P_RUN) ? {4'd0, cs_a_mem[m_upc][7:0], cs_b_mem[m_upc]} : 32'd0;
            e_val = 32'((m_ph == P_RUN) && ok);
            e_upc = 32'(m_upc);
            e_hlt = 32'(m_ph == P_STOP);
            e_err = 32'(m_err);
        end
        chk("instr_req", 32'(bus.instr_req), e_req);
        chk("dec_en", 32'(bus.dec_en), e_den);
        chk("dec_addr", 32'(bus.dec_addr), e_dad);
        chk("cs_en", 32'(bus.cs_en), e_cen);
        if (addr_known) chk("cs_addr", 32'(bus.cs_addr), e_cad);
        chk("ctrl_signals", 32'(bus.ctrl_signals), e_ctl);
        chk("ctrl_valid", 32'(bus.ctrl_valid), e_val);
        chk("upc", 32'(bus.upc), e_upc);
        chk("halted", 32'(bus.halted), e_hlt);
        chk("err", 32'(bus.err), e_err);
    endtask

    task automatic model_step();
        logic [7:0] nxt;
        logic [7:0] ret;
        int         go;
        logic       fault, ok;
        logic [3:0] op;
        if (rst) begin
            m_ph  = P_BOOT;
            m_upc = 8'd0;
            m_err = 1'b0;
            m_stack.delete();
        end else begin
            case (m_ph)
                P_BOOT: m_ph = P_IDLE;
                P_IDLE: begin
                    if (bus.instr_valid) begin
                        m_entry = dec_mem[bus.instruction[7:4]];
                        m_ph    = P_LOOKUP;
                    end
                end
                P_LOOKUP: begin
                    m_upc = m_entry;
                    m_ph  = P_RUN;
                end
                P_RUN: begin
                    decide(nxt, go, fault, ok);
                    op = cs_a_mem[m_upc][19:16];
                    if (fault) m_err = 1'b1;
                    if (go == 0) begin
                        ret = m_upc + 8'd1;
                        if (op == 4'd4) m_stack.push_back(ret);
                        else if (op == 4'd5) void'(m_stack.pop_back());
                        m_upc = nxt;
                    end else if (go == 1) begin
                        m_ph = P_IDLE;
                    end else begin
                        m_ph = P_STOP;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic issue(input logic [3:0] opc);
        int guard;
        guard = 0;
        while (m_ph != P_IDLE && guard < 40) begin
            tick();
            guard++;
        end
        if (m_ph != P_IDLE) begin
            n_vec++;
            n_bad++;
            $display("FAIL issue_wait: sequencer not ready after %0d cycles, required ready", guard);
        end
        bus.instr_valid = 1'b1;
        bus.instruction = {opc, 4'($urandom_range(0, 15))};
        tick();
        bus.instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic put(input logic [7:0] a, input logic [3:0] op, input logic [7:0] tgt);
        cs_a_mem[a] = {op, tgt, 8'($urandom)};
        cs_b_mem[a] = 20'($urandom);
    endtask

    task automatic randomize_mem();
        int r;
        for (int i = 0; i < 16; i++) dec_mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      put(8'(i), 4'($urandom_range(0, 7)), 8'($urandom));
            else if (r < 75) put(8'(i), 4'd15, 8'($urandom));
            else if (r < 78) put(8'(i), 4'($urandom_range(8, 14)), 8'($urandom));
            else             put(8'(i), 4'($urandom_range(0, 6)), 8'($urandom));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.instruction = 8'd0;
        bus.instr_valid = 1'b0;
        bus.flag_z      = 1'b0;
        bus.flag_c      = 1'b0;
        bus.ext_ready   = 1'b1;
        m_ph            = P_BOOT;
        m_upc           = 8'd0;
        m_entry         = 8'd0;
        m_err           = 1'b0;

        randomize_mem();
        dec_mem[3] = 8'h10;
        cs_a_mem[8'h10] = {OP_NEXT, 8'h00, 8'hA5};
        cs_b_mem[8'h10] = 20'h12345;
        put(8'h11, OP_FETCH, 8'h00);
        dec_mem[1] = 8'h20;
        put(8'h20, OP_BRZ, 8'h40);
        put(8'h40, OP_FETCH, 8'h00);
        put(8'h21, OP_FETCH, 8'h00);
        dec_mem[2] = 8'h30;
        put(8'h30, OP_CALL, 8'h50);
        put(8'h50, OP_RET, 8'h00);
        put(8'h31, OP_FETCH, 8'h00);
        dec_mem[4] = 8'h60;
        for (int i = 0; i < 5; i++) put(8'(8'h60 + i), OP_CALL, 8'(8'h61 + i));
        dec_mem[5] = 8'h70;
        put(8'h70, OP_WAIT, 8'h00);
        put(8'h71, OP_FETCH, 8'h00);
        dec_mem[6] = 8'hFF;
        put(8'hFF, OP_NEXT, 8'h00);
        put(8'h00, OP_FETCH, 8'h00);
        dec_mem[7] = 8'h80;
        put(8'h80, 4'd9, 8'h00);
        dec_mem[8] = 8'h90;
        for (int i = 0; i < 3; i++) put(8'(8'h90 + i), OP_NEXT, 8'h00);
        put(8'h93, OP_JUMP, 8'h90);
        dec_mem[9] = 8'hA0;
        put(8'hA0, OP_HALT, 8'h00);

        #1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("boot_upc", 32'(bus.upc), 32'h0);
        chk("boot_req", 32'(bus.instr_req), 32'h0);
        chk("boot_err", 32'(bus.err), 32'h0);

        // fetch, decode, NEXT then FETCH
        issue(4'h3);
        tick();
        #1;
        chk("t2_valid", 32'(bus.ctrl_valid), 32'h1);
        chk("t2_upc", 32'(bus.upc), 32'h10);
        chk("t2_word", 32'(bus.ctrl_signals), 32'hA512345);
        tick();
        #1;
        chk("t3_upc", 32'(bus.upc), 32'h11);
        chk("t3_valid", 32'(bus.ctrl_valid), 32'h1);
        tick();
        #1;
        chk("t4_req", 32'(bus.instr_req), 32'h1);
        chk("t4_valid", 32'(bus.ctrl_valid), 32'h0);

        bus.flag_z = 1'b1;
        issue(4'h1);
        tick();
        tick();
        #1;
        chk("brz_taken_upc", 32'(bus.upc), 32'h40);
        chk("brz_taken_valid", 32'(bus.ctrl_valid), 32'h1);
        chk("model_brz_taken", 32'(m_upc), 32'h40);
        tick();
        bus.flag_z = 1'b0;
        issue(4'h1);
        tick();
        tick();
        #1;
        chk("brz_fall_upc", 32'(bus.upc), 32'h21);
        chk("brz_fall_valid", 32'(bus.ctrl_valid), 32'h1);
        tick();

        issue(4'h2);
        tick();
        tick();
        #1;
        chk("call_upc", 32'(bus.upc), 32'h50);
        tick();
        #1;
        chk("ret_upc", 32'(bus.upc), 32'h31);
        chk("ret_valid", 32'(bus.ctrl_valid), 32'h1);
        chk("model_ret", 32'(m_upc), 32'h31);
        tick();

        issue(4'h4);
        for (int i = 0; i < 20 && m_ph != P_STOP; i++) tick();
        #1;
        chk("ovf_err", 32'(bus.err), 32'h1);
        chk("ovf_halted", 32'(bus.halted), 32'h1);
        chk("ovf_valid", 32'(bus.ctrl_valid), 32'h0);
        do_reset();

        bus.ext_ready = 1'b0;
        issue(4'h5);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wait_valid_low", 32'(bus.ctrl_valid), 32'h0);
            chk("wait_upc_hold", 32'(bus.upc), 32'h70);
            tick();
        end
        bus.ext_ready = 1'b1;
        #1;
        chk("wait_commit", 32'(bus.ctrl_valid), 32'h1);
        tick();
        #1;
        chk("wait_next_upc", 32'(bus.upc), 32'h71);
        tick();

        issue(4'h6);
        tick();
        #1;
        chk("wrap_ff", 32'(bus.upc), 32'hFF);
        tick();
        #1;
        chk("wrap_00", 32'(bus.upc), 32'h00);
        chk("wrap_valid", 32'(bus.ctrl_valid), 32'h1);
        tick();

        issue(4'h7);
        tick();
        tick();
        #1;
        chk("illegal_err", 32'(bus.err), 32'h1);
        chk("illegal_halted", 32'(bus.halted), 32'h1);
        chk("illegal_valid", 32'(bus.ctrl_valid), 32'h0);
        do_reset();

        issue(4'h9);
        tick();
        tick();
        #1;
        chk("halt_halted", 32'(bus.halted), 32'h1);
        chk("halt_err", 32'(bus.err), 32'h0);
        do_reset();

        issue(4'h8);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(bus.ctrl_valid), 32'h0);
        chk("rst_mid_word", 32'(bus.ctrl_signals), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_upc", 32'(bus.upc), 32'h0);
        chk("post_rst_req", 32'(bus.instr_req), 32'h0);
        tick();
        #1;
        chk("post_rst_req_back", 32'(bus.instr_req), 32'h1);

        for (int ep = 0; ep < 16; ep++) begin
            rst = 1'b1;
            randomize_mem();
            tick();
            rst = 1'b0;
            for (int c = 0; c < 200; c++) begin
                bus.instr_valid = ($urandom_range(0, 1) == 1);
                bus.instruction = 8'($urandom);
                bus.flag_z      = 1'($urandom);
                bus.flag_c      = 1'($urandom);
                bus.ext_ready   = ($urandom_range(0, 3) != 0);
                rst             = ($urandom_range(0, 199) == 0);
                tick();
            end
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
